out_channel_drain: RTL and testbench
====================================

// Module: out_channel_drain
// PURPOSE
//   Downstream of the program interpreter's out instruction: buffers every output word in a
//   circular FIFO of NOut elements and streams it to the host over a valid/ready interface.
//   Sticky overflow flag, running word count, and a drained flag once the program has
//   finished and every buffered word has been consumed.
// PARAMETERS
//   MemoryElementWidth  12    width of one output word
//   NOut                2000  FIFO depth in words; need not be a power of two
//   CW                  $clog2(NOut+1)  occupancy counter width (derived, localparam)
// PORTS
//   clock        in   1      single clock, all state changes on posedge
//   reset        in   1      asynchronous, active-high; clears all state
//   out_we       in   1      interpreter executed an out instruction this cycle (no backpressure)
//   out_word     in   MemoryElementWidth  word written by that instruction
//   finished     in   1      program finished; level, may stay high
//   host_valid   out  1      host_data holds a valid word
//   host_data    out  MemoryElementWidth  word at read pointer
//   host_ready   in   1      host accepts host_data this cycle
//   count        out  CW     words currently buffered
//   words_total  out  32     words accepted since reset, saturates at 2^32-1
//   overflow     out  1      sticky: a write was dropped
//   drained      out  1      finished seen and FIFO emptied
// BEHAVIOUR
//   Reset (async, immediate): wr_ptr=rd_ptr=0, count=0, words_total=0, overflow=0,
//     drained=0, state=IDLE; host_valid low in the same cycle as reset asserts.
//   host_valid = (count!=0) && state!=DONE; host_data = mem[rd_ptr] (combinational read).
//   push = out_we && (count<NOut || pop) && state!=FLUSH && state!=DONE.
//   pop  = host_valid && host_ready.
//   Pointers advance by 1 and wrap NOut-1 -> 0. count: +1 on push only, -1 on pop only,
//     unchanged on both.
//   Latency: word pushed at edge k gives host_valid=1 in the cycle after edge k (if FIFO was empty).
//   Full (count==NOut) with pop in same cycle: write accepted, count stays NOut.
//   Full without pop, or out_we while FLUSH/DONE: word dropped, overflow<=1 (sticky until reset),
//     pointers/count/words_total unchanged.
//   Empty with host_ready: no pop; host_data is don't-care.
//   words_total +1 on each push, holds at 32'hFFFF_FFFF.
//   States:
//     IDLE   : out_we -> STREAM; finished -> FLUSH (out_we in same cycle still pushed).
//     STREAM : finished -> FLUSH (out_we in same cycle still pushed).
//     FLUSH  : pop only; when count==0, or count==1 with pop -> DONE.
//     DONE   : drained=1, host_valid=0; held until reset.
//   Any new push clears nothing; flags change only as stated above.
// TESTING
//   1 Write 1,2,3 on consecutive cycles, host_ready=1 -> host_data 1,2,3 in order, each one
//     cycle after its write; count peaks 1; words_total=3.
//   2 host_ready=0, NOut=4, write 5 words -> count=4, overflow=1, words_total=4;
//     then drain -> words 1..4, 5th absent.
//   3 Full FIFO, out_we and host_ready in same cycle -> write accepted, count stays 4,
//     overflow stays 0.
//   4 NOut=3, 7 writes interleaved with reads -> pointer wrap, output order exactly
//     matches input order.
//   5 Write 1,2,3, assert finished, host_ready=1 -> drained=1 the cycle after last pop;
//     later out_we sets overflow, host_valid stays 0.
//   6 Assert reset mid-stream with count=2 -> outputs zero at once, host_valid=0;
//     after release write 9 -> host_data=9.

Source files
------------

// File: rtl/out_channel_drain_if.sv
// Host-side stream bundle for out_channel_drain: interpreter write strobe plus
// the valid/ready channel that carries buffered words to the host.
interface out_channel_drain_if #(
    parameter int unsigned Width = 12
);
    logic             out_we;
    logic [Width-1:0] out_word;
    logic             host_valid;
    logic [Width-1:0] host_data;
    logic             host_ready;

    // Environment side: drives writes and host acceptance.
    modport master (
        output out_we,
        output out_word,
        output host_ready,
        input  host_valid,
        input  host_data
    );

    // Buffer side.
    modport slave (
        input  out_we,
        input  out_word,
        input  host_ready,
        output host_valid,
        output host_data
    );
endinterface

// File: rtl/out_channel_drain.sv
// Circular FIFO between the interpreter's out instruction and the host stream,
// with sticky overflow, saturating word count and a drained flag after finish.
module out_channel_drain #(
    parameter int unsigned MemoryElementWidth = 12,
    parameter int unsigned NOut               = 2000,
    localparam int unsigned CW                = $clog2(NOut + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    out_channel_drain_if.slave    bus,
    input  logic                  finished,
    output logic [CW-1:0]         count,
    output logic [31:0]           words_total,
    output logic                  overflow,
    output logic                  drained
);
    localparam int unsigned PW = (NOut > 1) ? $clog2(NOut) : 1;

    typedef enum logic [1:0] {StIdle, StStream, StFlush, StDone} state_e;

    state_e                        state_q;
    logic [MemoryElementWidth-1:0] mem [NOut];
    logic [PW-1:0]                 wr_ptr_q;
    logic [PW-1:0]                 rd_ptr_q;
    logic                          push;
    logic                          pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NOut - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        bus.host_valid = (count != '0) && (state_q != StDone);
        bus.host_data  = mem[rd_ptr_q];
        pop            = bus.host_valid && bus.host_ready;
        // A full buffer still accepts a write when the head leaves in the same cycle.
        push           = bus.out_we && ((count < CW'(NOut)) || pop) &&
                         (state_q != StFlush) && (state_q != StDone);
    end

    // Storage is not reset; only words below count are ever presented as valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.out_word;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count       <= '0;
            words_total <= '0;
            overflow    <= 1'b0;
            drained     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (push && (words_total != 32'hFFFF_FFFF)) begin
                words_total <= words_total + 32'd1;
            end
            if (bus.out_we && !push) begin
                overflow <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (finished) begin
                        state_q <= StFlush;
                    end else if (bus.out_we) begin
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (finished) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if ((count == '0) || ((count == CW'(1)) && pop)) begin
                        state_q <= StDone;
                        drained <= 1'b1;
                    end
                end
                StDone: begin
                    drained <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_out_channel_drain.sv
// Drives two buffers (depth 4 and depth 3) with shared stimulus and checks each
// against a queue-based reference model every cycle.
module tb_out_channel_drain;
    localparam int W  = 12;
    localparam int NA = 4;
    localparam int NB = 3;

    logic         clock;
    logic         reset;
    logic         out_we;
    logic [W-1:0] out_word;
    logic         host_ready;
    logic         finished;

    logic [2:0]   count_a;
    logic [1:0]   count_b;
    logic [31:0]  total_a, total_b;
    logic         ovf_a, ovf_b, drn_a, drn_b;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = depth NA, index 1 = depth NB.
    logic [W-1:0] mq [2][$];
    longint       mtot [2];
    bit           movf [2];
    bit           mclosed [2];
    bit           mdone [2];

    out_channel_drain_if #(.Width(W)) if_a ();
    out_channel_drain_if #(.Width(W)) if_b ();

    assign if_a.out_we     = out_we;
    assign if_a.out_word   = out_word;
    assign if_a.host_ready = host_ready;
    assign if_b.out_we     = out_we;
    assign if_b.out_word   = out_word;
    assign if_b.host_ready = host_ready;

    out_channel_drain #(.MemoryElementWidth(W), .NOut(NA)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .bus         (if_a),
        .finished    (finished),
        .count       (count_a),
        .words_total (total_a),
        .overflow    (ovf_a),
        .drained     (drn_a)
    );

    out_channel_drain #(.MemoryElementWidth(W), .NOut(NB)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .bus         (if_b),
        .finished    (finished),
        .count       (count_b),
        .words_total (total_b),
        .overflow    (ovf_b),
        .drained     (drn_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    function automatic int depth(input int i);
        return (i == 0) ? NA : NB;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            mtot[i]    = 0;
            movf[i]    = 1'b0;
            mclosed[i] = 1'b0;
            mdone[i]   = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic         v;
            logic [W-1:0] d;
            logic [31:0]  c, t;
            logic         o, dr;
            bit           ev;
            if (i == 0) begin
                v = if_a.host_valid; d = if_a.host_data; c = 32'(count_a);
                t = total_a; o = ovf_a; dr = drn_a;
            end else begin
                v = if_b.host_valid; d = if_b.host_data; c = 32'(count_b);
                t = total_b; o = ovf_b; dr = drn_b;
            end
            ev = (mq[i].size() != 0) && !mdone[i];
            chk("host_valid", i, 32'(v), 32'(ev));
            if (ev) chk("host_data", i, 32'(d), 32'(mq[i][0]));
            chk("count", i, c, 32'(mq[i].size()));
            chk("words_total", i, t, 32'(mtot[i]));
            chk("overflow", i, 32'(o), 32'(movf[i]));
            chk("drained", i, 32'(dr), 32'(mdone[i]));
        end
    endtask

    // Apply one clock edge worth of the buffering rules to the model.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit ev, pop, push;
            ev   = (mq[i].size() != 0) && !mdone[i];
            pop  = ev && host_ready;
            push = out_we && ((mq[i].size() < depth(i)) || pop) && !mclosed[i];
            if (out_we && !push) movf[i] = 1'b1;
            if (pop) void'(mq[i].pop_front());
            if (push) begin
                mq[i].push_back(out_word);
                if (mtot[i] != 64'hFFFF_FFFF) mtot[i]++;
            end
            if (mclosed[i] && mq[i].size() == 0) mdone[i] = 1'b1;
            if (finished) mclosed[i] = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        check_all();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        out_we     = 1'b0;
        out_word   = '0;
        host_ready = 1'b0;
        finished   = 1'b0;
        reset      = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic write(input logic [W-1:0] w, input logic rdy);
        out_we     = 1'b1;
        out_word   = w;
        host_ready = rdy;
        cycle();
        out_we     = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();

        // In-order streaming with one-cycle latency
        host_ready = 1'b1;
        for (int w = 1; w <= 3; w++) write(12'(w), 1'b1);
        repeat (3) cycle();
        chk("t1_total", 0, total_a, 32'd3);

        // Overflow on a full buffer, then drain
        do_reset();
        for (int w = 1; w <= 5; w++) write(12'(w), 1'b0);
        cycle();
        chk("t2_count", 0, 32'(count_a), 32'd4);
        chk("t2_ovf", 0, 32'(ovf_a), 32'd1);
        host_ready = 1'b1;
        repeat (6) cycle();

        // Write and pop together while full
        do_reset();
        for (int w = 1; w <= 4; w++) write(12'(w), 1'b0);
        write(12'hABC, 1'b1);
        host_ready = 1'b0;
        cycle();
        chk("t3_count", 0, 32'(count_a), 32'd4);
        chk("t3_ovf", 0, 32'(ovf_a), 32'd0);
        host_ready = 1'b1;
        repeat (6) cycle();

        // Interleaved writes and reads, pointer wrap
        do_reset();
        for (int k = 0; k < 7; k++) write(12'($urandom), 1'($urandom_range(0, 1)));
        host_ready = 1'b1;
        repeat (6) cycle();

        // Random traffic, finishing late in the run
        do_reset();
        for (int k = 0; k < 300; k++) begin
            out_we     = ($urandom_range(0, 9) < 6);
            out_word   = 12'($urandom);
            host_ready = 1'($urandom_range(0, 1));
            finished   = (k > 250);
            cycle();
        end

        // Finish with the last write, then drained and post-finish drop
        do_reset();
        write(12'd1, 1'b1);
        write(12'd2, 1'b1);
        finished = 1'b1;
        write(12'd3, 1'b1);
        cycle();
        chk("t5_drained", 0, 32'(drn_a), 32'd1);
        write(12'd7, 1'b1);
        cycle();
        chk("t5_ovf", 0, 32'(ovf_a), 32'd1);
        chk("t5_valid", 0, 32'(if_a.host_valid), 32'd0);

        // Asynchronous reset mid-stream
        do_reset();
        write(12'd4, 1'b0);
        write(12'd5, 1'b0);
        chk("t6_pre_count", 0, 32'(count_a), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid", 0, 32'(if_a.host_valid), 32'd0);
        chk("t6_count", 0, 32'(count_a), 32'd0);
        chk("t6_total", 0, total_a, 32'd0);
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
        write(12'd9, 1'b0);
        chk("t6_data", 0, 32'(if_a.host_data), 32'd9);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
